// File: rtl/clock_disp_pkg.sv
// ---------------------------------------------------------------------------
// clock_disp_pkg
// Shared constants and types for the time display scanner:
//   - active-low 7-segment patterns {g,f,e,d,c,b,a} for 0..9, dash and off
//   - digit count and per-digit masks (decimal points, hour pair, minute pair)
//   - disp_out_t: the registered pin bundle {AN, SEG, DP}, plus its idle value
// ---------------------------------------------------------------------------
package clock_disp_pkg;

  localparam int N_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

  // Separator points sit after the hour, minute and second pairs.
  localparam logic [N_DIGITS-1:0] DP_MASK   = 8'b0101_0100;
  localparam logic [N_DIGITS-1:0] HOUR_MASK = 8'hC0;
  localparam logic [N_DIGITS-1:0] MIN_MASK  = 8'h30;

  typedef struct packed {
    logic [N_DIGITS-1:0] an;
    seg_t                seg;
    logic                dp;
  } disp_out_t;

  // All digits off, all segments dark, decimal point dark.
  localparam disp_out_t DISP_IDLE = '{an: '1, seg: SEG_OFF, dp: 1'b1};

endpackage

// File: rtl/time_display_scan_if.sv
// ---------------------------------------------------------------------------
// time_display_scan_if
// Bundle between the clock counter side and the display scanner.
//   master: drives CE10, TIME, SETH, SETM; observes AN, SEG, DP
//   slave : the scanner; consumes the time/set inputs, drives the pins
// ---------------------------------------------------------------------------
interface time_display_scan_if;
  import clock_disp_pkg::*;

  logic                CE10;
  logic [31:0]         TIME;
  logic                SETH;
  logic                SETM;
  logic [N_DIGITS-1:0] AN;
  seg_t                SEG;
  logic                DP;

  modport master (output CE10, TIME, SETH, SETM, input AN, SEG, DP);
  modport slave  (input CE10, TIME, SETH, SETM, output AN, SEG, DP);

endinterface

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Purely combinational BCD nibble to active-low 7-segment pattern.
//   i_nib : BCD digit; 10..15 are not valid BCD and show a dash
//   o_seg : {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    o_seg = SEG_DASH;
    case (i_nib)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// ---------------------------------------------------------------------------
// time_display_scan
// Multiplexes the packed BCD time word {HH,MM,ss,mm} onto an 8-digit
// common-anode display with leading-zero suppression on the hour tens,
// blinking of the hour/minute pair while it is being set, and separator
// decimal points.
//   CLK        : system clock
//   RST        : synchronous, active-high reset
//   bus.CE10   : centisecond strobe, paces the blink counter
//   bus.TIME   : {HH,MM,ss,mm} BCD, digit i = TIME[4i+3:4i]
//   bus.SETH/M : hour/minute set active, the matching pair blinks
//   bus.AN     : digit enables, active-low (registered)
//   bus.SEG    : segments {g,f,e,d,c,b,a}, active-low (registered)
//   bus.DP     : decimal point, active-low (registered)
// ---------------------------------------------------------------------------
module time_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_HALF = 50
) (
  input  logic               CLK,
  input  logic               RST,
  time_display_scan_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IW = $clog2(N_DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [3:0]          r_nib;
  logic [BW-1:0]       r_blink_cnt;
  logic                r_phase;
  disp_out_t           r_out;

  logic                w_guard;
  logic                w_wrap;
  logic                w_latch;
  logic [IW-1:0]       w_lat_idx;
  logic [3:0]          w_lat_nib;
  logic [N_DIGITS-1:0] w_sel;
  logic                w_blank;
  seg_t                w_seg;
  disp_out_t           w_next;

  assign w_guard = (r_presc == '0);
  assign w_wrap  = (r_presc == PRESC_LAST);

  // The nibble is captured on the wrap edge for the incoming digit and
  // refreshed once more as the slot leaves its guard cycle, so the value
  // shown for the rest of the slot is TIME as seen at the slot start and
  // the first slot after reset shows real data rather than the reset zero.
  assign w_latch   = w_wrap | w_guard;
  assign w_lat_idx = w_wrap ? r_idx + 1'b1 : r_idx;
  assign w_lat_nib = bus.TIME[{w_lat_idx, 2'b00} +: 4];

  assign w_sel = N_DIGITS'(1) << r_idx;

  // Hour tens suppressed when zero; set pairs go dark in the blink-on phase.
  assign w_blank = (w_sel[N_DIGITS-1] && (r_nib == 4'd0))
                || (r_phase && bus.SETH && |(w_sel & HOUR_MASK))
                || (r_phase && bus.SETM && |(w_sel & MIN_MASK));

  seg7_decode u_decode (
    .i_nib (r_nib),
    .o_seg (w_seg)
  );

  always_comb begin
    w_next = DISP_IDLE;
    // Guard cycle keeps all anodes off while the segment lines settle.
    w_next.an = w_guard ? '1 : ~w_sel;
    if (!w_blank) begin
      w_next.seg = w_seg;
      w_next.dp  = ~|(w_sel & DP_MASK);
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (RST) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_nib       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_out       <= DISP_IDLE;
    end else begin
      if (w_wrap) begin
        r_presc <= '0;
        r_idx   <= r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (w_latch) begin
        r_nib <= w_lat_nib;
      end

      if (bus.CE10) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end

      r_out <= w_next;
    end
  end

  assign bus.AN  = r_out.an;
  assign bus.SEG = r_out.seg;
  assign bus.DP  = r_out.dp;

endmodule

// File: tb/tb_time_display_scan.sv
// ---------------------------------------------------------------------------
// tb_time_display_scan
// Scoreboard bench for time_display_scan with SCAN_DIV=4, BLINK_HALF=2.
// Each cycle the reference model predicts the registered pins for the coming
// edge and queues them; after the edge the prediction is popped and compared.
// Targeted spot checks with literal expectations cover the key scenarios.
// ---------------------------------------------------------------------------
module tb_time_display_scan;

  localparam int SCAN_DIV   = 4;
  localparam int BLINK_HALF = 2;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk;
  logic rst;

  time_display_scan_if dif ();

  time_display_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  exp_t       sb [$];
  int         n_vec = 0;
  int         n_err = 0;

  int         m_presc = 0;
  int         m_idx   = 0;
  int         m_cnt   = 0;
  logic [3:0] m_nib   = 4'd0;
  bit         m_phase = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib_of(input int i);
    return dif.TIME[4*i +: 4];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   blank;
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (!rst) begin
      blank = 1'b0;
      if (m_idx == 7 && m_nib == 4'd0)                          blank = 1'b1;
      if (m_phase && dif.SETH && (m_idx == 6 || m_idx == 7))    blank = 1'b1;
      if (m_phase && dif.SETM && (m_idx == 4 || m_idx == 5))    blank = 1'b1;
      e.an  = (m_presc == 0) ? 8'hFF : ~(8'h01 << m_idx);
      e.seg = blank ? 7'h7F : seg_tab[m_nib];
      e.dp  = (!blank && (m_idx == 2 || m_idx == 4 || m_idx == 6)) ? 1'b0 : 1'b1;
    end
    return e;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_presc = 0;
      m_idx   = 0;
      m_nib   = 4'd0;
      m_cnt   = 0;
      m_phase = 1'b0;
    end else begin
      if (m_presc == 0) m_nib = nib_of(m_idx);
      if (m_presc == SCAN_DIV - 1) begin
        m_nib   = nib_of((m_idx + 1) % 8);
        m_presc = 0;
        m_idx   = (m_idx + 1) % 8;
      end else begin
        m_presc++;
      end
      if (dif.CE10) begin
        if (m_cnt == BLINK_HALF - 1) begin
          m_cnt   = 0;
          m_phase = !m_phase;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    sb.push_back(model_out());
    @(posedge clk);
    model_update();
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_AN",  dif.AN,  e.an);
      check("sb_SEG", dif.SEG, e.seg);
      check("sb_DP",  dif.DP,  e.dp);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model holds the given digit/prescaler state.
  task automatic run_to(input int idx, input int presc);
    int n;
    n = 0;
    while (!(m_idx == idx && m_presc == presc) && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) check("run_to_bound", n, 0);
  endtask

  task automatic pulse_ce10();
    dif.CE10 = 1'b1;
    step();
    dif.CE10 = 1'b0;
    steps(3);
  endtask

  initial begin
    rst      = 1'b1;
    dif.CE10 = 1'b0;
    dif.SETH = 1'b0;
    dif.SETM = 1'b0;
    dif.TIME = 32'h1234_5678;
    #2;
    steps(3);
    check("rst_AN",  dif.AN,  8'hFF);
    check("rst_SEG", dif.SEG, 7'h7F);
    check("rst_DP",  dif.DP,  1'b1);

    // Reset release: guard, then digit 0 shows 8, digit 1 shows 7.
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1 || c == 5) check("rel_guard_AN", dif.AN, 8'hFF);
      if (c >= 2 && c <= 4) begin
        check("rel_d0_AN",  dif.AN,  8'hFE);
        check("rel_d0_SEG", dif.SEG, 7'h00);
      end
      if (c == 6) begin
        check("rel_d1_AN",  dif.AN,  8'hFD);
        check("rel_d1_SEG", dif.SEG, 7'h78);
      end
    end

    // Leading-zero suppression on the hour tens.
    dif.TIME = 32'h0930_0000;
    steps(8);
    run_to(7, 1);
    step();
    check("lz_d7_AN",  dif.AN,  8'h7F);
    check("lz_d7_SEG", dif.SEG, 7'h7F);
    run_to(6, 1);
    step();
    check("lz_d6_SEG", dif.SEG, 7'h10);

    // Invalid BCD dash, and a mid-slot TIME change held off to the next slot.
    dif.TIME = 32'h0000_A000;
    steps(8);
    run_to(3, 2);
    dif.TIME = 32'h0000_5000;
    step();
    check("mid_hold_SEG0", dif.SEG, 7'h3F);
    step();
    check("mid_hold_SEG1", dif.SEG, 7'h3F);
    run_to(3, 1);
    step();
    check("mid_next_SEG", dif.SEG, 7'h12);

    // Minute blink: two CE10 pulses move the phase to 1.
    dif.TIME = 32'h1234_5678;
    dif.SETM = 1'b1;
    steps(8);
    pulse_ce10();
    pulse_ce10();
    run_to(4, 1);
    step();
    check("blk_m_d4_SEG", dif.SEG, 7'h7F);
    check("blk_m_d4_DP",  dif.DP,  1'b1);
    run_to(6, 1);
    step();
    check("blk_m_d6_SEG", dif.SEG, 7'h24);
    check("blk_m_d6_DP",  dif.DP,  1'b0);

    // Both pairs blinking.
    dif.SETH = 1'b1;
    run_to(7, 1);
    step();
    check("blk_hm_d7_AN",  dif.AN,  8'h7F);
    check("blk_hm_d7_SEG", dif.SEG, 7'h7F);
    run_to(3, 1);
    step();
    check("blk_hm_d3_SEG", dif.SEG, 7'h12);

    // Pulses 3 and 4 bring the phase back to 0: minute digits visible again.
    pulse_ce10();
    pulse_ce10();
    run_to(5, 1);
    step();
    check("blk_off_d5_SEG", dif.SEG, 7'h30);
    dif.SETH = 1'b0;
    dif.SETM = 1'b0;
    steps(8);

    // Reset in the middle of the digit 5 slot.
    run_to(5, 2);
    rst = 1'b1;
    step();
    check("mrst_AN",  dif.AN,  8'hFF);
    check("mrst_SEG", dif.SEG, 7'h7F);
    check("mrst_DP",  dif.DP,  1'b1);
    rst = 1'b0;
    step();
    check("mrst_guard_AN", dif.AN, 8'hFF);
    step();
    check("mrst_d0_AN",  dif.AN,  8'hFE);
    check("mrst_d0_SEG", dif.SEG, 7'h00);
    steps(34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_display_scan.md
Name: time_display_scan

Overview:
- Reads the packed BCD time word from the clock counter, TIME = {HH, MM, ss, mm} with 8 bits per field and two BCD nibbles each.
- Drives a multiplexed 8-digit, common-anode, active-low 7-segment display.
- Also handles leading-zero suppression, field blinking during hour/minute set, and separator decimal points.
- Sits between the clock counter and the board display pins.

Parameters:
- SCAN_DIV, 1000: CLK cycles per digit slot; legal minimum 2.
- BLINK_HALF, 50: CE10 pulses per blink half-period (1 Hz blink with 100 Hz CE10).

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset, synchronous, active-high.
- CE10  input  1  one-cycle centisecond enable, same strobe that feeds the clock counter.
- TIME  input  32  {HH, MM, ss, mm}, BCD; TIME[3:0] = centisecond ones, TIME[31:28] = hour tens.
- SETH  input  1  hour-set active; hour digits blink.
- SETM  input  1  minute-set active; minute digits blink.
- AN  output  8  digit enables, active-low; AN[i] selects digit i.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.

Behaviour:
- Reset:
  - Prescaler = 0, digit index = 0, blink phase = 0, latched nibble = 0.
  - AN = 8'hFF, SEG = 7'h7F, DP = 1.
  - RST mid-scan has the same effect at the next edge and overrides all other activity.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge the digit index increments, 7 wraps to 0.
- Nibble latch:
  - On the edge where the prescaler goes to 0, latch TIME[4*i+3:4*i] for the new index i.
  - TIME changes inside a slot are not shown until the next slot.
- Guard cycle: while prescaler == 0, AN = 8'hFF (anti-ghosting); SEG/DP still update.
- Output registers:
  - AN, SEG and DP are registered.
  - In cycle k+1 they reflect the index, nibble and prescaler values held in cycle k.
  - Enabled digit: AN = ~(1<<i) when prescaler != 0.
- Decode of latched nibble to SEG (active-low):
  - 0→40, 1→79, 2→24, 3→30, 4→19
  - 5→12, 6→02, 7→78, 8→00, 9→10
  - 10..15 (invalid BCD)→3F, a dash.
- Blanking, which forces SEG = 7F and DP = 1:
  - Digit 7 when its nibble == 0 (leading-zero suppression).
  - Digits 7,6 when SETH=1 and blink phase=1.
  - Digits 5,4 when SETM=1 and blink phase=1.
  - SETH and SETM together blink both pairs.
  - AN still scans normally while blanked.
- DP: 0 on digits 2, 4 and 6 when not blanked; 1 elsewhere.
- Blink counter:
  - Counts CE10 pulses 0..BLINK_HALF-1.
  - The pulse that arrives at terminal count wraps the counter and toggles the phase.
  - Without CE10 the phase holds.
  - SETH/SETM falling does not reset the phase.

Decomposition:
- Package clock_disp_pkg holds:
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - N_DIGITS = 8.
  - DP_MASK = 8'b0101_0100.
  - HOUR_MASK = 8'hC0, MIN_MASK = 8'h30.
- One combinational sub-module, seg7_decode: nibble in, SEG pattern out.
- Prescaler, scan index, blink counter and output registers stay in the top module.

Test Plan (SCAN_DIV=4, BLINK_HALF=2):
- Reset release, TIME=32'h12345678:
  - Cycle 1: AN=FF (guard).
  - Cycles 2-4: AN=FE, SEG=00 (digit 8).
  - Next slot: AN=FD, SEG=78.
  - Full 32-cycle frame shows 8,7,6,5,4,3,2,1 on digits 0..7.
  - DP=0 only during the slots of digits 2, 4, 6.
- TIME=32'h09_30_00_00: digit 7 slot gives AN=7F and SEG=7F; digit 6 gives SEG=10.
- TIME nibble = A on digit 3 → SEG=3F for that slot. Change TIME mid-slot → SEG unchanged until the next slot.
- SETM=1, four CE10 pulses:
  - Phase toggles after pulses 2 and 4.
  - While phase=1, digits 5,4 give SEG=7F and DP=1.
  - Digits 7,6 are unaffected.
- SETH=SETM=1, phase=1 → digits 7..4 blanked, digits 3..0 normal.
- Assert RST during digit 5 slot → next edge AN=FF, SEG=7F; after release the scan restarts at digit 0.
